// File: rtl/seg7_scan_driver_if.sv
// Interface between the UART receive datapath (master) and the seven-segment
// scan driver (slave).
//   value      : hex nibbles, nibble k = value[4k+3:4k] drives digit k (k=0 rightmost)
//   load       : 1-cycle strobe capturing value into the shadow register
//   blank_mask : bit k=1 forces digit k dark, sampled live
//   an         : anode enables, active-low, at most one bit low
//   LED        : segments a..g = LED[6:0], active-low
//   frame_done : 1-cycle pulse on the cycle the active buffer is (re)loaded
// Handshake: load is a plain strobe with no ready; the driver always accepts
// it on the cycle it is high.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   blank_mask;
    logic [DIGITS-1:0]   an;
    logic [6:0]          LED;
    logic                frame_done;

    modport master (
        output value, load, blank_mask,
        input  an, LED, frame_done
    );

    modport slave (
        input  value, load, blank_mask,
        output an, LED, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. One digit is scanned per
// refresh slot of REFRESH_DIV clocks; the first GUARD clocks of each slot keep
// all anodes off to avoid ghosting. The displayed value is double-buffered: a
// load goes to the shadow register and is promoted to the active register only
// at the frame wrap, so a frame never shows a mix of two values.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : seg7_scan_driver_if.slave (value/load/blank_mask in, an/LED/frame_done out)
// Optional feature: define LEADING_ZERO_BLANK_EN to darken digits above the
// highest nonzero nibble of the active value (digit 0 always stays lit).
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scan_driver_if.slave    bus
);
    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] GUARD_T    = TW'(GUARD);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

    logic [TW-1:0]     tick_q, tick_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [VW-1:0]     shadow_q, shadow_d;
    logic [VW-1:0]     active_q, active_d;
    logic              pending_q, pending_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        led_q, led_d;
    logic              frame_done_q, frame_done_d;

    logic       slot_end;
    logic       wrap;
    logic [3:0] nibble;
    logic       dark;
`ifdef LEADING_ZERO_BLANK_EN
    logic [DW-1:0] lit_limit;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        tick_d       = tick_q + TW'(1);
        digit_d      = digit_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        an_d         = '1;
        led_d        = 7'b1111111;
        frame_done_d = 1'b0;
        nibble       = 4'h0;
        dark         = 1'b0;

        slot_end = (tick_q == TICK_LAST);
        wrap     = slot_end && (digit_q == DIGIT_LAST);

        if (slot_end) begin
            tick_d  = '0;
            digit_d = wrap ? '0 : digit_q + DW'(1);
        end

        if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end

        // A load on the wrap cycle itself bypasses the shadow register.
        if (wrap && (pending_q || bus.load)) begin
            active_d     = bus.load ? bus.value : shadow_q;
            pending_d    = 1'b0;
            frame_done_d = 1'b1;
        end

        // Mux out the current digit's nibble and its live blank bit.
        for (int k = 0; k < DIGITS; k++) begin
            if (digit_q == DW'(k)) begin
                nibble = active_q[4*k +: 4];
                dark   = bus.blank_mask[k];
            end
        end

`ifdef LEADING_ZERO_BLANK_EN
        // Highest index holding a nonzero nibble; stays 0 for an all-zero value
        // so digit 0 still shows "0".
        lit_limit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (active_q[4*k +: 4] != 4'h0) begin
                lit_limit = DW'(k);
            end
        end
        if (digit_q > lit_limit) begin
            dark = 1'b1;
        end
`endif

        // Outputs are computed from this cycle's slot position and registered.
        if ((tick_q >= GUARD_T) && !dark) begin
            an_d  = ~(DIGITS'(1) << digit_q);
            led_d = seg_decode(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q       <= '0;
            digit_q      <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            led_q        <= 7'b1111111;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            led_q        <= led_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.LED        = led_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
    localparam int D  = 4;
    localparam int RD = 4;
    localparam int GD = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seg7_scan_driver_if #(.DIGITS(D)) bus ();

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Segment table straight from the display code list.
    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // ---------------- behavioural model ----------------
    // Slot position is derived from a free-running count of cycles since
    // reset; the buffers are tracked as plain values.
    int          m_n = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_active = '0;
    bit          m_pend = 0;
    bit          model_ok = 0;
    logic [3:0]  e_an = '1;
    logic [6:0]  e_led = '1;
    logic        e_fd = 1'b0;

    always @(posedge clk) begin
        int  tk;
        int  dg;
        bit  is_dark;
        bit  is_wrap;
        logic [15:0] shifted;
        if (reset) begin
            m_n = 0; m_shadow = '0; m_active = '0; m_pend = 0;
            e_an = '1; e_led = '1; e_fd = 1'b0;
            model_ok = 1;
        end else begin
            tk = m_n % RD;
            dg = (m_n / RD) % D;
            is_dark = bus.blank_mask[dg];
`ifdef LEADING_ZERO_BLANK_EN
            shifted = m_active >> (4 * dg);
            if (dg > 0 && shifted == 16'h0) is_dark = 1;
`endif
            if (tk < GD || is_dark) begin
                e_an = '1; e_led = '1;
            end else begin
                shifted = m_active >> (4 * dg);
                e_an  = ~(4'b0001 << dg);
                e_led = seg_tab[shifted[3:0]];
            end
            is_wrap = (tk == RD - 1) && (dg == D - 1);
            e_fd = is_wrap && (m_pend || bus.load);
            if (e_fd) begin
                m_active = bus.load ? bus.value : m_shadow;
                m_pend = 0;
                if (bus.load) m_shadow = bus.value;
            end else if (bus.load) begin
                m_shadow = bus.value;
                m_pend = 1;
            end
            m_n++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (bus.an !== e_an || bus.LED !== e_led || bus.frame_done !== e_fd) begin
                errors++;
                $display("FAIL model t=%0t an=%b LED=%b fd=%b expected an=%b LED=%b fd=%b",
                         $time, bus.an, bus.LED, bus.frame_done, e_an, e_led, e_fd);
            end
        end
    end

    // ---------------- driver / literal checks ----------------
    int fd_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        bus.value = v; bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        while (bus.frame_done !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        if (bus.frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s frame_done timeout actual=0 expected=1", name);
        end
    endtask

    // Called on the cycle frame_done is seen; checks each slot's first ON cycle.
    task automatic check_frame(input string name, input logic [27:0] leds, input logic [3:0] dk);
        logic [3:0] xa;
        logic [6:0] xl;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if ((i - 1) % 4 == 1) begin
                if (dk[(i - 1) / 4]) begin
                    xa = 4'b1111; xl = 7'b1111111;
                end else begin
                    xa = ~(4'b0001 << ((i - 1) / 4));
                    xl = leds[7 * ((i - 1) / 4) +: 7];
                end
                check({name, "_an"}, 32'(bus.an), 32'(xa));
                check({name, "_led"}, 32'(bus.LED), 32'(xl));
            end
        end
    endtask

    initial begin
        int n;
        int fd0;
        bus.value = '0; bus.load = 1'b0; bus.blank_mask = '0;

        // Reset held three cycles.
        step(3);
        check("reset_an", 32'(bus.an), 32'hF);
        check("reset_led", 32'(bus.LED), 32'h7F);
        check("reset_fd", 32'(bus.frame_done), 32'h0);
        reset = 1'b0;
        step(1);
        check("guard_an", 32'(bus.an), 32'hF);
        step(1);
        check("first_an", 32'(bus.an), 32'hE);

        // 12AF: digit0=F, 1=A, 2=2, 3=1.
        fd0 = fd_cnt;
        do_load(16'h12AF);
        wait_fd("t2");
        check_frame("t2", {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b0000);
        check("t2_fd_once", 32'(fd_cnt - fd0), 32'd1);

        // Last load before the wrap wins.
        fd0 = fd_cnt;
        do_load(16'h1111);
        step(4);
        do_load(16'h2222);
        wait_fd("t3");
        check_frame("t3", {4{7'b0010010}}, 4'b0000);
        step(16);
        check("t3_fd_once", 32'(fd_cnt - fd0), 32'd1);

        // Load on the wrap cycle bypasses a pending shadow value.
        do_load(16'h5555);
        n = 0;
        while (m_n % 16 != 15 && n < 20) begin
            step(1);
            n++;
        end
        bus.value = 16'h0F00; bus.load = 1'b1;
        step(1);
        bus.load = 1'b0;
        check("t4_fd_at_wrap", 32'(bus.frame_done), 32'h1);
        check_frame("t4", {7'b0000001, 7'b0111000, 7'b0000001, 7'b0000001}, 4'b0000);

        // Live blank mask.
        bus.blank_mask = 4'b0100;
        do_load(16'h8888);
        wait_fd("t5");
        check_frame("t5", {4{7'b0000000}}, 4'b0100);
        bus.blank_mask = 4'b0000;

        // Leading-zero handling.
        do_load(16'h0030);
        wait_fd("t6a");
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("t6a", {7'b0, 7'b0, 7'b0000110, 7'b0000001}, 4'b1100);
`else
        check_frame("t6a", {7'b0000001, 7'b0000001, 7'b0000110, 7'b0000001}, 4'b0000);
`endif
        do_load(16'h0000);
        wait_fd("t6b");
`ifdef LEADING_ZERO_BLANK_EN
        check_frame("t6b", {7'b0, 7'b0, 7'b0, 7'b0000001}, 4'b1110);
`else
        check_frame("t6b", {4{7'b0000001}}, 4'b0000);
`endif

        // Reset mid-scan discards the pending load.
        do_load(16'hABCD);
        step(2);
        @(negedge clk);
        reset = 1'b1;
        step(1);
        check("midrst_an", 32'(bus.an), 32'hF);
        check("midrst_led", 32'(bus.LED), 32'h7F);
        check("midrst_fd", 32'(bus.frame_done), 32'h0);
        reset = 1'b0;
        fd0 = fd_cnt;
        step(40);
        check("midrst_no_fd", 32'(fd_cnt - fd0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
